// File: rtl/game_pkg.sv
// Shared game-state encodings and default level parameters for the game logic slice.
package game_pkg;

  typedef enum logic [1:0] {
    GAME_INITIAL = 2'b00,
    GAME_RUNNING = 2'b01,
    GAME_OVER    = 2'b10,
    GAME_SUCCESS = 2'b11
  } game_state_t;

  localparam int TIME_LIMIT_DEF = 300;
  localparam int LIVES_DEF      = 3;
  localparam int GOAL_X_DEF     = 3000;

endpackage

// File: rtl/tick_divider.sv
// Prescaler: counts enabled cycles 0..TICKS-1 and pulses tick on the wrap cycle.
module tick_divider #(
  parameter int TICKS = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [W-1:0] MAX = W'(TICKS - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == MAX) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = en && !clr && (cnt == MAX);

endmodule

// File: rtl/game_judge.sv
// Level referee: countdown timer, lives, post-hit invulnerability and goal detection,
// producing the over/success levels consumed by the game-state FSM.
module game_judge
  import game_pkg::*;
#(
  parameter int TICKS_PER_SEC = 25_000_000,
  parameter int TIME_LIMIT    = TIME_LIMIT_DEF,
  parameter int LIVES         = LIVES_DEF,
  parameter int GOAL_X        = GOAL_X_DEF,
  parameter int INVULN_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  state,
  input  logic        hit,
  input  logic        fell,
  input  logic [11:0] mario_x,
  output logic        over,
  output logic        success,
  output logic [8:0]  time_left,
  output logic [2:0]  lives,
  output logic        invuln,
  output logic        respawn
);

  localparam int INV_W = (INVULN_CYCLES > 1) ? $clog2(INVULN_CYCLES) : 1;
  localparam logic [INV_W-1:0] INV_LOAD = INV_W'(INVULN_CYCLES - 1);
  localparam logic [11:0]      GOAL     = 12'(GOAL_X);

  logic             running, initial_st;
  logic             sec_tick;
  logic             hit_d;
  logic [INV_W-1:0] inv_cnt;

  logic       hit_ev, fall_ev, loss;
  logic [8:0] time_nx;
  logic [2:0] lives_nx;
  logic       lost_nx, goal;

  assign running    = (state == GAME_RUNNING);
  assign initial_st = (state == GAME_INITIAL);

  tick_divider #(.TICKS(TICKS_PER_SEC)) u_div (
    .clk  (clk),
    .rst  (rst),
    .en   (running),
    .clr  (initial_st),
    .tick (sec_tick)
  );

  always_comb begin
    hit_ev   = hit && !hit_d && !invuln;
    fall_ev  = fell && !respawn;
    loss     = hit_ev || fall_ev;
    time_nx  = (sec_tick && time_left != '0) ? time_left - 1'b1 : time_left;
    lives_nx = (loss && lives != '0) ? lives - 1'b1 : lives;
    // Checking the next values covers both "reaching zero now" and "already zero".
    lost_nx  = (time_nx == '0) || (lives_nx == '0);
    goal     = (mario_x >= GOAL);
  end

  always_ff @(posedge clk) begin
    if (rst || initial_st) begin
      over      <= 1'b0;
      success   <= 1'b0;
      respawn   <= 1'b0;
      invuln    <= 1'b0;
      inv_cnt   <= '0;
      hit_d     <= 1'b0;
      time_left <= 9'(TIME_LIMIT);
      lives     <= 3'(LIVES);
    end else if (running) begin
      hit_d     <= hit;
      time_left <= time_nx;
      lives     <= lives_nx;
      respawn   <= fall_ev;
      // Once one outcome is latched the other can never be raised.
      over      <= over || (lost_nx && !success);
      success   <= success || (goal && !lost_nx && !over);
      if (loss) begin
        invuln  <= 1'b1;
        inv_cnt <= INV_LOAD;
      end else if (invuln) begin
        if (inv_cnt == '0) begin
          invuln <= 1'b0;
        end else begin
          inv_cnt <= inv_cnt - 1'b1;
        end
      end
    end else begin
      respawn <= 1'b0;
    end
  end

endmodule

// File: tb/tb_game_judge.sv
// Bench for game_judge: directed scenarios plus random traffic against a cycle-level reference model.
module tb_game_judge;

  localparam int TPS  = 4;
  localparam int TL   = 3;
  localparam int LV   = 3;
  localparam int GX   = 100;
  localparam int INVC = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  state;
  logic        hit, fell;
  logic [11:0] mario_x;
  logic        over, success, invuln, respawn;
  logic [8:0]  time_left;
  logic [2:0]  lives;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  int  m_elapsed;
  int  m_lives;
  int  m_inv_left;
  bit  m_hit_prev;
  bit  m_respawn;
  bit  m_over, m_success;

  always #5 clk = ~clk;

  game_judge #(
    .TICKS_PER_SEC (TPS),
    .TIME_LIMIT    (TL),
    .LIVES         (LV),
    .GOAL_X        (GX),
    .INVULN_CYCLES (INVC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .state     (state),
    .hit       (hit),
    .fell      (fell),
    .mario_x   (mario_x),
    .over      (over),
    .success   (success),
    .time_left (time_left),
    .lives     (lives),
    .invuln    (invuln),
    .respawn   (respawn)
  );

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int m_time();
    int t;
    t = TL - m_elapsed / TPS;
    return (t < 0) ? 0 : t;
  endfunction

  // Advance the model by one clock using the inputs currently applied, then compare.
  task automatic step();
    int  e_n, l_n, t_n, inv_n;
    bit  hev, fev, loss, lost, ov_n, su_n, rs_n, hp_n;
    e_n = m_elapsed; l_n = m_lives; inv_n = m_inv_left;
    ov_n = m_over; su_n = m_success; rs_n = 1'b0; hp_n = m_hit_prev;
    if (rst || state == 2'b00) begin
      e_n = 0; l_n = LV; inv_n = 0; ov_n = 0; su_n = 0; hp_n = 0;
    end else if (state == 2'b01) begin
      e_n  = m_elapsed + 1;
      t_n  = TL - e_n / TPS;
      if (t_n < 0) t_n = 0;
      hev  = hit && !m_hit_prev && (m_inv_left == 0);
      fev  = fell && !m_respawn;
      loss = hev || fev;
      if (loss && m_lives > 0) l_n = m_lives - 1;
      lost = (t_n == 0) || (l_n == 0);
      ov_n = m_over || (lost && !m_success);
      su_n = m_success || ((int'(mario_x) >= GX) && !lost && !m_over);
      rs_n = fev;
      hp_n = hit;
      if (loss) inv_n = INVC;
      else if (m_inv_left > 0) inv_n = m_inv_left - 1;
    end
    @(posedge clk);
    m_elapsed = e_n; m_lives = l_n; m_inv_left = inv_n;
    m_over = ov_n; m_success = su_n; m_respawn = rs_n; m_hit_prev = hp_n;
    #1;
    check("over",      over,      m_over);
    check("success",   success,   m_success);
    check("time_left", time_left, m_time());
    check("lives",     lives,     m_lives);
    check("invuln",    invuln,    m_inv_left > 0);
    check("respawn",   respawn,   m_respawn);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_hit();
    hit = 1'b1; step(); hit = 1'b0;
  endtask

  task automatic pulse_fell();
    fell = 1'b1; step(); fell = 1'b0;
  endtask

  task automatic reload();
    state = 2'b00; hit = 0; fell = 0; mario_x = '0;
    step();
    state = 2'b01;
  endtask

  initial begin
    rst = 1'b1; state = 2'b00; hit = 0; fell = 0; mario_x = '0;
    m_elapsed = 0; m_lives = LV; m_inv_left = 0; m_hit_prev = 0;
    m_respawn = 0; m_over = 0; m_success = 0;
    run(2);
    check("rst_time", time_left, 3);
    check("rst_lives", lives, 3);
    rst = 1'b0;

    // timeout
    state = 2'b01;
    run(12);
    check("timeout_over", over, 1);
    check("timeout_time", time_left, 0);
    check("timeout_succ", success, 0);
    run(3);
    state = 2'b10;
    run(20);
    check("freeze_time", time_left, 0);
    reload();
    check("reload_time", time_left, 3);
    check("reload_over", over, 0);

    // hit and invulnerability
    pulse_hit();
    check("hit1_lives", lives, 2);
    run(2);
    pulse_hit();
    check("hit_masked", lives, 2);
    run(6);
    pulse_hit();
    check("hit2_lives", lives, 1);
    reload();

    // held hit costs one life
    hit = 1'b1;
    run(20);
    hit = 1'b0;
    check("held_hit_lives", lives, 2);
    reload();

    // falls (not masked by invuln) down to zero lives
    for (int i = 0; i < 3; i++) begin
      pulse_fell();
      run(1);
    end
    check("fall_lives", lives, 0);
    check("fall_over", over, 1);
    reload();

    // goal in the same cycle as the last life loss
    pulse_fell(); run(1);
    pulse_fell(); run(1);
    mario_x = 12'd100;
    pulse_fell();
    check("goal_vs_over_o", over, 1);
    check("goal_vs_over_s", success, 0);
    run(2);
    reload();

    // goal with lives remaining, then freeze in SUCCESS
    mario_x = 12'd100;
    step();
    check("goal_succ", success, 1);
    state = 2'b11;
    run(10);
    check("succ_freeze_t", time_left, 3);
    reload();

    // rst mid-RUNNING
    pulse_hit();
    run(5);
    rst = 1'b1; step(); rst = 1'b0;
    check("midrst_lives", lives, 3);
    check("midrst_time", time_left, 3);

    // random traffic
    state = 2'b01;
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3)       state = 2'b00;
      else if (r < 8)  state = 2'b10;
      else if (r < 13) state = 2'b11;
      else if (r < 90) state = 2'b01;
      rst     = ($urandom_range(0, 199) == 0);
      hit     = ($urandom_range(0, 3) == 0);
      fell    = ($urandom_range(0, 9) == 0);
      mario_x = ($urandom_range(0, 19) == 0) ? 12'($urandom_range(98, 4095))
                                             : 12'($urandom_range(0, 99));
      step();
    end
    rst = 0; hit = 0; fell = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
